// File: rtl/sb_pkg.sv
// Shared definitions for the sum scoreboard: status encoding and state type.
// Optional feature macro used by sum_scoreboard: SB_FIRST_MISS_CAPTURE_EN.
package sb_pkg;

  localparam int SB_STATUS_W = 2;

  localparam logic [SB_STATUS_W-1:0] SB_IDLE = 2'd0;
  localparam logic [SB_STATUS_W-1:0] SB_PASS = 2'd1;
  localparam logic [SB_STATUS_W-1:0] SB_FAIL = 2'd2;

  // The status port presents the state register directly, so the encodings must match.
  typedef enum logic [SB_STATUS_W-1:0] {
    ST_IDLE = SB_IDLE,
    ST_PASS = SB_PASS,
    ST_FAIL = SB_FAIL
  } sb_state_e;

endpackage

// File: rtl/sb_fifo.sv
// Expected-value queue for sum_scoreboard: power-of-two ring buffer with
// an extra pointer bit to tell full from empty, plus a synchronous flush.
module sb_fifo #(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic                       pop,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign count = count_q;

  // Guarded here as well so a misbehaving caller cannot corrupt the pointers.
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;

  // NOTE: every variable gets its default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/sum_scoreboard.sv
// Compares queued expected sums against actual sums in arrival order, with
// saturating counters, pass/fail status and sticky flags. Macro: SB_FIRST_MISS_CAPTURE_EN.
module sum_scoreboard
  import sb_pkg::*;
#(
  parameter int DATA_W = 6,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       exp_valid,
  input  logic [DATA_W-1:0]          exp_data,
  output logic                       exp_ready,
  input  logic                       act_valid,
  input  logic [DATA_W-1:0]          act_data,
  output logic [CNT_W-1:0]           match_cnt,
  output logic [CNT_W-1:0]           miss_cnt,
  output logic                       mismatch,
  output logic [$clog2(DEPTH+1)-1:0] pending,
  output logic [1:0]                 status,
  output logic                       overflow,
  output logic                       underflow,
  output logic [DATA_W-1:0]          first_miss_exp,
  output logic [DATA_W-1:0]          first_miss_act
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [DATA_W-1:0] head;
  logic              fifo_full, fifo_empty;
  logic              push_ev, drop_ev, pop_ev, under_ev, match_ev, miss_ev;

  logic [CNT_W-1:0]  match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;
  logic              mismatch_q;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  sb_state_e         state_q, state_d;

  // Full/empty are pre-edge values, so a pop never frees room for a same-cycle push.
  assign push_ev  = exp_valid && !fifo_full && !clear;
  assign drop_ev  = exp_valid &&  fifo_full && !clear;
  assign pop_ev   = act_valid && !fifo_empty && !clear;
  assign under_ev = act_valid &&  fifo_empty && !clear;
  assign match_ev = pop_ev && (head == act_data);
  assign miss_ev  = (pop_ev && (head != act_data)) || under_ev;

  sb_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (clear),
    .push  (push_ev),
    .pop   (pop_ev),
    .wdata (exp_data),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending)
  );

  assign exp_ready = !fifo_full;

  always_comb begin
    match_cnt_d = match_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (clear) begin
      match_cnt_d = '0;
      miss_cnt_d  = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (match_ev && (match_cnt_q != CNT_MAX)) match_cnt_d = match_cnt_q + 1'b1;
      if (miss_ev && (miss_cnt_q != CNT_MAX))   miss_cnt_d  = miss_cnt_q + 1'b1;
      if (drop_ev)  overflow_d  = 1'b1;
      if (under_ev) underflow_d = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (miss_ev)       state_d = ST_FAIL;
          else if (match_ev) state_d = ST_PASS;
        end
        ST_PASS: if (miss_ev) state_d = ST_FAIL;
        ST_FAIL: state_d = ST_FAIL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_cnt_q <= '0;
      miss_cnt_q  <= '0;
      mismatch_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      state_q     <= ST_IDLE;
    end else begin
      match_cnt_q <= match_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      mismatch_q  <= miss_ev;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      state_q     <= state_d;
    end
  end

  assign match_cnt = match_cnt_q;
  assign miss_cnt  = miss_cnt_q;
  assign mismatch  = mismatch_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
  assign status    = state_q;

`ifdef SB_FIRST_MISS_CAPTURE_EN
  logic              captured_q, captured_d;
  logic [DATA_W-1:0] fm_exp_q, fm_exp_d;
  logic [DATA_W-1:0] fm_act_q, fm_act_d;

  always_comb begin
    captured_d = captured_q;
    fm_exp_d   = fm_exp_q;
    fm_act_d   = fm_act_q;
    if (clear) begin
      captured_d = 1'b0;
      fm_exp_d   = '0;
      fm_act_d   = '0;
    end else if (miss_ev && !captured_q) begin
      captured_d = 1'b1;
      fm_exp_d   = under_ev ? '0 : head;
      fm_act_d   = act_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      captured_q <= 1'b0;
      fm_exp_q   <= '0;
      fm_act_q   <= '0;
    end else begin
      captured_q <= captured_d;
      fm_exp_q   <= fm_exp_d;
      fm_act_q   <= fm_act_d;
    end
  end

  assign first_miss_exp = fm_exp_q;
  assign first_miss_act = fm_act_q;
`else
  assign first_miss_exp = '0;
  assign first_miss_act = '0;
`endif

endmodule
